hs_sync_sink: RTL and testbench

- Clocked sink stage directly downstream of the last asynchronous pipeline controller.
- Consumes the controller's 4-phase bundled-data output: req_out feeds req_in, the bundled data feeds data_in, and ack_in drives the controller's ack_out.
- Synchronises the request into the clk domain, captures the data into a small FWFT FIFO, and completes the return-to-zero handshake.
- Presents the captured words on a valid/ready interface to synchronous logic.

---
 rtl/hs_sync_sink.sv | 112 +++++++++++
 tb/tb_hs_sync_sink.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_sink.sv
// Clocked sink for a 4-phase bundled-data channel: synchronises req, captures data
// into a first-word-fall-through FIFO, and returns ack; drains via valid/ready.
module hs_sync_sink #(
    parameter int unsigned DATA_W      = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_in,
    input  logic [DATA_W-1:0]              data_in,
    output logic                           ack_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    req_s;
    logic                    full;
    logic                    push;
    logic                    pop;

    // Only the request crosses domains; data is held stable by the bundling constraint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign pop   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Push only on the IDLE->ACK transition so a long-held request captures once.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign ack_in    = (state_q == ACK);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: tb/tb_hs_sync_sink.sv
// Bench for hs_sync_sink: a 4-phase upstream driver feeds a word queue; a negedge
// monitor checks every popped word and the occupancy against handshakes minus pops.
module tb_hs_sync_sink;

    localparam int unsigned DATA_W      = 2;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb_q[$];
    int  acked;
    int  popped;
    logic prev_ack;
    bit  rand_ready;

    hs_sync_sink #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_in(req_in),
        .data_in(data_in),
        .ack_in(ack_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Words handed off (ack rises) minus words popped is the expected occupancy.
    always @(negedge clk) begin
        if (!rst_n) begin
            acked    = 0;
            popped   = 0;
            prev_ack = 1'b0;
        end else begin
            if (ack_in && !prev_ack) acked++;
            prev_ack = ack_in;
            chk("count", int'(count), acked - popped);
            chk("out_valid", int'(out_valid), int'((acked - popped) != 0));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_with_empty_scoreboard", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(sb_q.pop_front()));
                end
                popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output int n);
        n = 0;
        while (ack_in !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (ack_in !== lvl) chk("ack_timeout", int'(ack_in), int'(lvl));
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int budget,
                        output int lat_up, output int lat_dn);
        data_in = d;
        req_in  = 1'b1;
        sb_q.push_back(d);
        wait_ack(1'b1, budget, lat_up);
        req_in = 1'b0;
        wait_ack(1'b0, budget, lat_dn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int up;
        int dn;
        logic [DATA_W-1:0] d;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        req_in     = 1'b1;
        data_in    = 2'b01;
        out_ready  = 1'b0;
        sb_q.push_back(2'b01);

        // Reset with request already high: fresh capture after release.
        #12;
        chk("rst_ack", int'(ack_in), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_out_data", int'(out_data), 0);
        tick();
        rst_n = 1'b1;
        wait_ack(1'b1, 20, up);
        chk("rst_release_ack_latency", up, SYNC_STAGES + 1);
        chk("rst_release_count", int'(count), 1);
        req_in = 1'b0;
        wait_ack(1'b0, 20, dn);
        chk("rst_release_fall_latency", dn, SYNC_STAGES + 1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Single transfer.
        send(2'b10, 20, up, dn);
        chk("single_up_latency", up, SYNC_STAGES + 1);
        chk("single_dn_latency", dn, SYNC_STAGES + 1);
        chk("single_out_data", int'(out_data), 2);
        chk("single_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_valid_after_pop", int'(out_valid), 0);

        // Backpressure: fifth word waits for a freed slot.
        for (int i = 0; i < 4; i++) send(2'(i), 20, up, dn);
        chk("bp_count_full", int'(count), 4);
        data_in = 2'b01;
        req_in  = 1'b1;
        sb_q.push_back(2'b01);
        repeat (8) tick();
        chk("bp_no_ack_when_full", int'(ack_in), 0);
        chk("bp_count_held", int'(count), 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_count_after_pop", int'(count), 3);
        wait_ack(1'b1, 20, up);
        chk("bp_ack_edge_after_pop", up, 1);
        chk("bp_count_refilled", int'(count), 4);
        req_in = 1'b0;
        wait_ack(1'b0, 20, dn);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        chk("bp_drained", int'(count), 0);

        // Simultaneous push and pop at count=2.
        send(2'b11, 20, up, dn);
        send(2'b00, 20, up, dn);
        data_in = 2'b10;
        req_in  = 1'b1;
        sb_q.push_back(2'b10);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("simul_ack", int'(ack_in), 1);
        chk("simul_count", int'(count), 2);
        req_in = 1'b0;
        wait_ack(1'b0, 20, dn);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;

        // Mid-handshake reset with three words held.
        send(2'b01, 20, up, dn);
        send(2'b10, 20, up, dn);
        data_in = 2'b11;
        req_in  = 1'b1;
        sb_q.push_back(2'b11);
        wait_ack(1'b1, 20, up);
        chk("midrst_pre_count", int'(count), 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_ack_async", int'(ack_in), 0);
        chk("midrst_count_async", int'(count), 0);
        chk("midrst_valid_async", int'(out_valid), 0);
        req_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_idle_ack", int'(ack_in), 0);
        chk("midrst_idle_count", int'(count), 0);

        // Wrap-around with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 2'($urandom);
            send(d, 20, up, dn);
        end
        repeat (4) tick();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d = 2'($urandom);
            send(d, 400, up, dn);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (10) tick();
        chk("final_scoreboard_empty", sb_q.size(), 0);
        chk("final_count", int'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
